// File: rtl/xif_offload_pkg.sv
// Shared types for the CPU-side CORE-V-XIF offload driver: FSM states,
// privilege mode and the latched instruction record.
package xif_offload_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    COMMIT = 2'd2
  } offload_state_e;

  localparam logic [1:0] PRIV_MODE_M = 2'b11;

  localparam int DEF_NUM_RS    = 3;
  localparam int DEF_RFR_WIDTH = 32;
  localparam int LATCH_RS_W    = DEF_NUM_RS * DEF_RFR_WIDTH;

  // The rs field is sized from the package defaults; the top derives its
  // operand parameters from the same constants.
  typedef struct packed {
    logic [31:0]           instr;
    logic [LATCH_RS_W-1:0] rs;
    logic                  kill;
  } latched_instr_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/xif_id_scoreboard.sv
// Outstanding-ID bitmap with an occupancy count; one set and one clear
// port per cycle, two independent query ports.
module xif_id_scoreboard #(
  parameter int X_ID_WIDTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set,
  input  logic [X_ID_WIDTH-1:0] set_id,
  input  logic                  clr,
  input  logic [X_ID_WIDTH-1:0] clr_id,
  input  logic [X_ID_WIDTH-1:0] query_a_id,
  output logic                  busy_a,
  input  logic [X_ID_WIDTH-1:0] query_b_id,
  output logic                  busy_b,
  output logic                  full
);

  localparam int NUM_IDS = 2 ** X_ID_WIDTH;
  localparam int CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [NUM_IDS-1:0] busy;
  logic [CW-1:0]      count;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= '0;
      count <= '0;
    end else begin
      if (set) busy[set_id] <= 1'b1;
      if (clr) busy[clr_id] <= 1'b0;
      // A set and a clear in the same cycle cancel in the count.
      if (set && !clr)      count <= count + 1'b1;
      else if (clr && !set) count <= count - 1'b1;
    end
  end

  assign busy_a = busy[query_a_id];
  assign busy_b = busy[query_b_id];
  assign full   = (count >= MAX_CNT);

endmodule

// File: rtl/xif_cpu_offload.sv
// CPU-side driver of the CORE-V-XIF issue/commit/result channels (flattened
// cpu_issue/cpu_commit/cpu_result modports). XIF_OFFLOAD_PERF_EN adds counters.
module xif_cpu_offload
  import xif_offload_pkg::*;
#(
  parameter int X_NUM_RS        = DEF_NUM_RS,
  parameter int X_ID_WIDTH      = 4,
  parameter int X_RFR_WIDTH     = DEF_RFR_WIDTH,
  parameter int X_RFW_WIDTH     = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            instr_valid,
  output logic                            instr_ready,
  input  logic [31:0]                     instr,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] instr_rs,
  input  logic                            instr_kill,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [31:0]                     issue_instr,
  output logic [1:0]                      issue_mode,
  output logic [X_ID_WIDTH-1:0]           issue_id,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs,
  output logic [X_NUM_RS-1:0]             issue_rs_valid,
  output logic [5:0]                      issue_ecs,
  output logic                            issue_ecs_valid,
  input  logic                            issue_accept,
  input  logic                            issue_writeback,
  output logic                            commit_valid,
  output logic [X_ID_WIDTH-1:0]           commit_id,
  output logic                            commit_kill,
  input  logic                            result_valid,
  output logic                            result_ready,
  input  logic [X_ID_WIDTH-1:0]           result_id,
  input  logic [X_RFW_WIDTH-1:0]          result_data,
  input  logic [4:0]                      result_rd,
  output logic                            wb_valid,
  output logic [4:0]                      wb_rd,
  output logic [X_RFW_WIDTH-1:0]          wb_data,
  output logic [X_ID_WIDTH-1:0]           wb_id,
  output logic                            reject_pulse,
  output logic                            unexp_result
`ifdef XIF_OFFLOAD_PERF_EN
  ,
  output logic [31:0]                     perf_issued,
  output logic [31:0]                     perf_rejected,
  output logic [31:0]                     perf_killed,
  output logic [31:0]                     perf_results
`endif
);

  offload_state_e        state, state_nxt;
  latched_instr_t        lat;
  logic [X_ID_WIDTH-1:0] next_id;
  logic                  wb_cap;
  logic                  take, id_adv, sb_set;
  logic                  issue_hs, res_hs, res_hit;
  logic                  busy_next, busy_res, sb_full;

  assign issue_hs = (state == ISSUE) && issue_ready;
  assign res_hs   = result_valid && result_ready;
  assign res_hit  = res_hs && busy_res;

  always_comb begin
    state_nxt    = state;
    instr_ready  = 1'b0;
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
    take         = 1'b0;
    id_adv       = 1'b0;
    sb_set       = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = result_ready && !sb_full && !busy_next;
        if (instr_valid && instr_ready) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (issue_ready) begin
          if (issue_accept) begin
            state_nxt = COMMIT;
          end else begin
            id_adv    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      COMMIT: begin
        commit_valid = 1'b1;
        sb_set       = !lat.kill && wb_cap;
        id_adv       = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat          <= '0;
      next_id      <= '0;
      wb_cap       <= 1'b0;
      result_ready <= 1'b0;
      reject_pulse <= 1'b0;
      unexp_result <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_id        <= '0;
    end else begin
      state        <= state_nxt;
      result_ready <= 1'b1;
      reject_pulse <= issue_hs && !issue_accept;
      unexp_result <= res_hs && !busy_res;
      wb_valid     <= res_hit;
      if (take) begin
        lat.instr <= instr;
        lat.rs    <= instr_rs;
        lat.kill  <= instr_kill;
      end
      if (issue_hs) wb_cap <= issue_writeback;
      if (id_adv)   next_id <= next_id + 1'b1;
      if (res_hit) begin
        wb_rd   <= result_rd;
        wb_data <= result_data;
        wb_id   <= result_id;
      end
    end
  end

  // Request fields come straight from the latch, so they hold while stalled.
  assign issue_instr     = lat.instr;
  assign issue_mode      = PRIV_MODE_M;
  assign issue_id        = next_id;
  assign issue_rs        = lat.rs;
  assign issue_rs_valid  = '1;
  assign issue_ecs       = '0;
  assign issue_ecs_valid = issue_valid;
  assign commit_id       = next_id;
  assign commit_kill     = lat.kill;

  // A result for the ID being committed this cycle sees a clear bit and is
  // reported as unexpected rather than racing the set.
  xif_id_scoreboard #(
    .X_ID_WIDTH     (X_ID_WIDTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set       (sb_set),
    .set_id    (next_id),
    .clr       (res_hit),
    .clr_id    (result_id),
    .query_a_id(next_id),
    .busy_a    (busy_next),
    .query_b_id(result_id),
    .busy_b    (busy_res),
    .full      (sb_full)
  );

`ifdef XIF_OFFLOAD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued   <= '0;
      perf_rejected <= '0;
      perf_killed   <= '0;
      perf_results  <= '0;
    end else begin
      if (issue_hs && issue_accept)   perf_issued   <= sat_inc(perf_issued);
      if (issue_hs && !issue_accept)  perf_rejected <= sat_inc(perf_rejected);
      if (commit_valid && lat.kill)   perf_killed   <= sat_inc(perf_killed);
      if (res_hit)                    perf_results  <= sat_inc(perf_results);
    end
  end
`endif

endmodule

// File: tb/tb_xif_cpu_offload.sv
// Directed bench for xif_cpu_offload: issue/commit/result round trips,
// stalls, rejects, kills, back-pressure, ID wrap and mid-issue reset.
module tb_xif_cpu_offload;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready, instr_kill;
  logic [31:0] instr;
  logic [95:0] instr_rs;
  logic        issue_valid, issue_ready, issue_ecs_valid;
  logic [31:0] issue_instr;
  logic [1:0]  issue_mode;
  logic [3:0]  issue_id;
  logic [95:0] issue_rs;
  logic [2:0]  issue_rs_valid;
  logic [5:0]  issue_ecs;
  logic        issue_accept, issue_writeback;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        result_valid, result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  wb_id;
  logic        reject_pulse, unexp_result;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] eid;

  always #5 clk = ~clk;

  xif_cpu_offload dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_rs(instr_rs), .instr_kill(instr_kill),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_mode(issue_mode), .issue_id(issue_id),
    .issue_rs(issue_rs), .issue_rs_valid(issue_rs_valid),
    .issue_ecs(issue_ecs), .issue_ecs_valid(issue_ecs_valid),
    .issue_accept(issue_accept), .issue_writeback(issue_writeback),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_data(result_data), .result_rd(result_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_id(wb_id),
    .reject_pulse(reject_pulse), .unexp_result(unexp_result)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one instruction through issue (with 'stall' cycles of issue_ready=0)
  // and the following commit or reject.
  task automatic send(input logic [31:0] ins, input logic kill, input logic [3:0] exp_id,
                      input logic acc, input logic wbk, input int stall);
    logic [95:0] rs;
    rs = {ins ^ 32'h3, ins ^ 32'h2, ins ^ 32'h1};
    for (int i = 0; i < 20 && !instr_ready; i++) tick();
    chk("instr_ready_wait", instr_ready, 1);
    instr_valid = 1'b1; instr = ins; instr_rs = rs; instr_kill = kill;
    tick();
    instr_valid = 1'b0; instr = 32'hDEAD_BEEF; instr_rs = '1; instr_kill = ~kill;
    issue_accept = acc; issue_writeback = wbk;
    for (int i = 0; i <= stall; i++) begin
      issue_ready = (i == stall);
      #1;
      chk("issue_valid", issue_valid, 1);
      chk("issue_instr", issue_instr, ins);
      chk("issue_id", issue_id, exp_id);
      chk("issue_rs", issue_rs, rs);
      chk("issue_mode", issue_mode, 2'b11);
      chk("commit_early", commit_valid, 0);
      tick();
    end
    issue_ready = 1'b0;
    if (acc) begin
      chk("commit_valid", commit_valid, 1);
      chk("commit_id", commit_id, exp_id);
      chk("commit_kill", commit_kill, kill);
      chk("reject_none", reject_pulse, 0);
      tick();
      chk("commit_once", commit_valid, 0);
    end else begin
      chk("reject_pulse", reject_pulse, 1);
      chk("no_commit", commit_valid, 0);
      chk("issue_drop", issue_valid, 0);
      tick();
      chk("reject_once", reject_pulse, 0);
      chk("no_commit2", commit_valid, 0);
    end
  endtask

  task automatic send_result(input logic [3:0] id, input logic [4:0] rd,
                             input logic [31:0] data, input logic exp_wb);
    result_valid = 1'b1; result_id = id; result_rd = rd; result_data = data;
    tick();
    result_valid = 1'b0;
    chk("wb_valid", wb_valid, exp_wb);
    chk("unexp_result", unexp_result, !exp_wb);
    if (exp_wb) begin
      chk("wb_data", wb_data, data);
      chk("wb_rd", wb_rd, rd);
      chk("wb_id", wb_id, id);
    end
    tick();
    chk("wb_pulse", wb_valid, 0);
    chk("unexp_pulse", unexp_result, 0);
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 0; instr = 0; instr_rs = 0; instr_kill = 0;
    issue_ready = 0; issue_accept = 0; issue_writeback = 0;
    result_valid = 0; result_id = 0; result_data = 0; result_rd = 0;
    repeat (3) tick();
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_reject", reject_pulse, 0);
    chk("rst_unexp", unexp_result, 0);
    chk("rst_result_ready", result_ready, 0);
    chk("rst_instr_ready", instr_ready, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_result_ready", result_ready, 1);
    chk("post_rst_instr_ready", instr_ready, 1);

    // FADD.S round trip
    send(32'h0020_8053, 0, 4'd0, 1, 1, 0);
    send_result(4'd0, 5'd0, 32'h4040_0000, 1);

    // issue stalled for 3 cycles
    send(32'h0010_8053, 0, 4'd1, 1, 1, 3);
    send_result(4'd1, 5'd5, 32'h0000_1234, 1);

    // reject: no commit, ID still advances
    send(32'h0030_8053, 0, 4'd2, 0, 1, 0);

    // killed instruction never enters the scoreboard
    send(32'h0040_8053, 1, 4'd3, 1, 1, 0);
    send_result(4'd3, 5'd7, 32'h0000_0077, 0);

    // fill to MAX_OUTSTANDING
    for (int k = 4; k < 8; k++) send(32'h0050_8053 + k, 0, 4'(k), 1, 1, 0);
    chk("full_instr_ready", instr_ready, 0);
    result_valid = 1'b1; result_id = 4'd4; result_rd = 5'd9; result_data = 32'hA5A5_0004;
    #1;
    chk("full_still_blocked", instr_ready, 0);
    tick();
    result_valid = 1'b0;
    chk("full_wb_valid", wb_valid, 1);
    chk("full_wb_data", wb_data, 32'hA5A5_0004);
    chk("drain_instr_ready", instr_ready, 1);
    tick();
    for (int k = 5; k < 8; k++) send_result(4'(k), 5'(k), 32'h1000_0000 + k, 1);

    // 17 round trips, ID wraps 15 -> 0
    eid = 4'd8;
    for (int k = 0; k < 17; k++) begin
      send(32'h0060_0053 + k, 0, eid, 1, 1, 0);
      send_result(eid, 5'(k), 32'h2000_0000 + k, 1);
      eid = eid + 4'd1;
    end
    chk("wrap_id", eid, 4'd9);

    // leave one outstanding, then reset during ISSUE
    send(32'h0070_0053, 0, eid, 1, 1, 0);
    instr_valid = 1'b1; instr = 32'h0080_0053; instr_kill = 0;
    tick();
    instr_valid = 1'b0;
    chk("pre_rst_issue_valid", issue_valid, 1);
    reset = 1'b1;
    tick();
    chk("rst_mid_issue_valid", issue_valid, 0);
    chk("rst_mid_commit", commit_valid, 0);
    reset = 1'b0;
    tick();
    chk("rst_mid_instr_ready", instr_ready, 1);
    send(32'h0090_0053, 0, 4'd0, 1, 0, 0);
    send_result(4'd9, 5'd1, 32'h0000_0009, 0);
    send_result(4'd0, 5'd1, 32'h0000_0000, 0);
    send(32'h00A0_0053, 0, 4'd1, 1, 1, 0);
    send_result(4'd1, 5'd31, 32'hCAFE_F00D, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
